// File: rtl/ro_meas_pkg.sv
// Shared types and helpers for the ring-oscillator measurement sequencer.
package ro_meas_pkg;

    // state | meaning
    // IDLE    | all rings disabled, waiting for a start request
    // SETTLE  | selected ring enabled, letting it and the synchronizer settle
    // MEASURE | gate window open, counting synchronized rising edges
    // FINISH  | ring disabled, result valid, done pulsed for one cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        FINISH  = 2'd3
    } measState_t;

    localparam int DEFAULT_SETTLE_CYC = 8;

    // Ring-select width; a single ring still gets a 1-bit select.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for one ring output, plus a third flop that turns
// the synchronized level into a single-cycle rising-edge pulse.
module ro_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic asyncIn,
    output logic risePulse
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Shift the raw ring output through the synchronizer and compare stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= asyncIn;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign risePulse = sync2 & ~sync3;

endmodule

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one ring at a time, waits
// for it to settle, counts its rising edges over a gate window of clk
// cycles, reports the count and disables the ring again.
//
// state | meaning
// IDLE    | all rings off; a valid start enables a ring, a bad sel flags sel_err
// SETTLE  | ring on, edges ignored while the ring and synchronizer settle
// MEASURE | gate down-counter running, synchronized edges counted (saturating)
// FINISH  | ring off, busy low, done high for this one cycle
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter  int N_RO       = 2,
    parameter  int GATE_W     = 16,
    parameter  int CNT_W      = 16,
    parameter  int SETTLE_CYC = DEFAULT_SETTLE_CYC,
    localparam int SEL_W      = selWidth(N_RO)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [SEL_W-1:0]  sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [N_RO-1:0]   ro_clk,
    output logic [N_RO-1:0]   ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              sel_err
);

    localparam int                SCNT_W      = $clog2(SETTLE_CYC) + 1;
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]    SEL_LIMIT   = (SEL_W + 1)'(N_RO);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    measState_t        state;
    measState_t        stateNext;
    logic [SEL_W-1:0]  selReg;
    logic [GATE_W-1:0] gateReg;
    logic [GATE_W-1:0] gateCnt;
    logic [SCNT_W-1:0] settleCnt;
    logic [N_RO-1:0]   enReg;
    logic [N_RO-1:0]   enOneHot;
    logic [CNT_W-1:0]  countReg;
    logic              overflowReg;
    logic              selErrReg;
    logic              errDone;
    logic              accept;
    logic              errStart;
    logic              selBad;
    logic              settleZero;
    logic              gateZero;
    logic              loadGate;
    logic              countEn;
    logic              edgePulse;

    assign selBad     = ({1'b0, sel} >= SEL_LIMIT);
    assign enOneHot   = N_RO'(1) << sel;
    assign settleZero = (settleCnt == '0);
    assign gateZero   = (gateCnt == '0);
    assign loadGate   = (state == SETTLE) && settleZero;
    assign countEn    = (state == MEASURE) && !gateZero && edgePulse;

    // selReg only changes on an accepted start, so the mux is static while busy.
    ro_edge_sync u_edgeSync (
        .clk       (clk),
        .reset     (reset),
        .asyncIn   (ro_clk[selReg]),
        .risePulse (edgePulse)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode; a start during the error done pulse is ignored too.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        errStart  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !errDone) begin
                    if (selBad) begin
                        errStart = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        stateNext = SETTLE;
                    end
                end
            end
            SETTLE:  if (settleZero) stateNext = MEASURE;
            MEASURE: if (gateZero) stateNext = FINISH;
            FINISH:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Latches, timers, ring enable and the saturating edge counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            selReg      <= '0;
            gateReg     <= '0;
            gateCnt     <= '0;
            settleCnt   <= '0;
            enReg       <= '0;
            countReg    <= '0;
            overflowReg <= 1'b0;
            selErrReg   <= 1'b0;
            errDone     <= 1'b0;
        end else begin
            errDone <= errStart;
            if (errStart) begin
                selErrReg <= 1'b1;
                countReg  <= '0;
            end
            if (accept) begin
                selReg    <= sel;
                gateReg   <= gate_cycles;
                settleCnt <= SETTLE_LOAD;
                enReg     <= enOneHot;
                selErrReg <= 1'b0;
            end
            if ((state == SETTLE) && !settleZero) begin
                settleCnt <= settleCnt - 1'b1;
            end
            if (loadGate) begin
                gateCnt     <= gateReg;
                countReg    <= '0;
                overflowReg <= 1'b0;
            end
            if (state == MEASURE) begin
                if (gateZero) begin
                    enReg <= '0;
                end else begin
                    gateCnt <= gateCnt - 1'b1;
                end
            end
            // An edge arriving with the counter already full is a lost edge.
            if (countEn) begin
                if (countReg == CNT_MAX) begin
                    overflowReg <= 1'b1;
                end else begin
                    countReg <= countReg + 1'b1;
                end
            end
        end
    end

    assign ro_en    = enReg;
    assign busy     = (state == SETTLE) || (state == MEASURE);
    assign done     = (state == FINISH) || errDone;
    assign count    = countReg;
    assign overflow = overflowReg;
    assign sel_err  = selErrReg;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl: default instance (2 rings, 16-bit count)
// and a narrow instance (3 rings, 4-bit count) for saturation and bad select.
module tb_ro_meas_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        ringA0 = 1'b0;
    logic        ringA1 = 1'b0;
    logic        ringB0 = 1'b0;

    logic        startA;
    logic [0:0]  selA;
    logic [15:0] gateA;
    logic [1:0]  roA;
    logic [1:0]  roEnA;
    logic        busyA, doneA, ovfA, selErrA;
    logic [15:0] countA;

    logic        startB;
    logic [1:0]  selB;
    logic [15:0] gateB;
    logic [2:0]  roB;
    logic [2:0]  roEnB;
    logic        busyB, doneB, ovfB, selErrB;
    logic [3:0]  countB;

    int          nAssert = 0;
    int          nFail   = 0;
    int          enErrA  = 0;
    int          enErrB  = 0;
    bit          monOn   = 1'b0;
    logic [1:0]  expEnA  = '0;
    logic [2:0]  expEnB  = '0;
    int          lat;

    assign roA = {ringA1, ringA0};
    assign roB = {2'b00, ringB0};

    ro_meas_ctrl u_dutA (
        .clk (clk), .reset (reset), .start (startA), .sel (selA),
        .gate_cycles (gateA), .ro_clk (roA), .ro_en (roEnA), .busy (busyA),
        .done (doneA), .count (countA), .overflow (ovfA), .sel_err (selErrA)
    );

    ro_meas_ctrl #(.N_RO(3), .CNT_W(4)) u_dutB (
        .clk (clk), .reset (reset), .start (startB), .sel (selB),
        .gate_cycles (gateB), .ro_clk (roB), .ro_en (roEnB), .busy (busyB),
        .done (doneB), .count (countB), .overflow (ovfB), .sel_err (selErrB)
    );

    // Behavioural rings: 8, 14 and 4 clk periods, phase-offset from clk.
    initial begin #3; forever #40 ringA0 = ~ringA0; end
    initial begin #7; forever #70 ringA1 = ~ringA1; end
    initial begin #2; forever #20 ringB0 = ~ringB0; end

    // Enables must match the expected one-hot while busy and be zero otherwise.
    always @(negedge clk) begin
        if (monOn) begin
            if (busyA ? (roEnA != expEnA) : (roEnA != 2'b00)) enErrA++;
            if (busyB ? (roEnB != expEnB) : (roEnB != 3'b000)) enErrB++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        nAssert++;
        if (obs != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic kickA(input logic [0:0] s, input logic [15:0] g);
        selA   = s;
        gateA  = g;
        startA = 1'b1;
        expEnA = 2'b01 << s;
        @(negedge clk);
        startA = 1'b0;
    endtask

    task automatic kickB(input logic [1:0] s, input logic [15:0] g);
        selB   = s;
        gateB  = g;
        startB = 1'b1;
        expEnB = 3'b001 << s;
        @(negedge clk);
        startB = 1'b0;
    endtask

    task automatic waitDone(input bit onB, input int lat0, output int latOut);
        latOut = lat0;
        while (!(onB ? doneB : doneA) && latOut < 2000) begin
            @(negedge clk);
            latOut++;
        end
    endtask

    initial begin
        reset = 1'b1;
        startA = 1'b0; selA = '0; gateA = '0;
        startB = 1'b0; selB = '0; gateB = '0;
        repeat (3) @(negedge clk);
        chk("rst_ro_en", roEnA, 0);
        chk("rst_busy", busyA, 0);
        chk("rst_done", doneA, 0);
        chk("rst_count", countA, 0);
        chk("rst_overflow", ovfA, 0);
        chk("rst_sel_err", selErrA, 0);
        chk("rstB_ro_en", roEnB, 0);
        chk("rstB_done", doneB, 0);
        reset = 1'b0;
        monOn = 1'b1;
        @(negedge clk);

        // Ring 0, period 8, 80-cycle window.
        kickA(1'b0, 16'd80);
        chk("t1_busy", busyA, 1);
        chk("t1_ro_en", roEnA, 2'b01);
        waitDone(1'b0, 1, lat);
        chk("t1_latency", lat, 90);
        chk("t1_count_10pm1", (countA >= 9 && countA <= 11), 1);
        chk("t1_overflow", ovfA, 0);
        chk("t1_ro_en_done", roEnA, 0);
        chk("t1_busy_done", busyA, 0);
        @(negedge clk);
        chk("t1_done_one_cycle", doneA, 0);
        chk("t1_enable_monitor", enErrA, 0);

        // Ring 1, period 14, 140-cycle window, ring 0 still toggling.
        kickA(1'b1, 16'd140);
        waitDone(1'b0, 1, lat);
        chk("t2_latency", lat, 150);
        chk("t2_count_10pm1", (countA >= 9 && countA <= 11), 1);
        chk("t2_overflow", ovfA, 0);
        chk("t2_enable_monitor", enErrA, 0);
        @(negedge clk);

        // 4-bit counter, period-4 ring, 100-cycle window saturates.
        kickB(2'd0, 16'd100);
        waitDone(1'b1, 1, lat);
        chk("t3_latency", lat, 110);
        chk("t3_count_sat", countB, 15);
        chk("t3_overflow", ovfB, 1);
        chk("t3_ro_en_done", roEnB, 0);
        @(negedge clk);

        // Out-of-range select on the 3-ring instance.
        kickB(2'd3, 16'd50);
        chk("t4_done", doneB, 1);
        chk("t4_sel_err", selErrB, 1);
        chk("t4_count", countB, 0);
        chk("t4_busy", busyB, 0);
        chk("t4_ro_en", roEnB, 0);
        @(negedge clk);
        chk("t4_done_one_cycle", doneB, 0);
        chk("t4_sel_err_hold", selErrB, 1);
        kickB(2'd1, 16'd0);
        chk("t4_sel_err_cleared", selErrB, 0);
        waitDone(1'b1, 1, lat);
        chk("t4_valid_latency", lat, 10);
        chk("t4_valid_count", countB, 0);
        chk("t4_valid_overflow", ovfB, 0);
        chk("t4_enable_monitor", enErrB, 0);
        @(negedge clk);

        // Start while busy with a different sel and gate is ignored.
        kickA(1'b0, 16'd80);
        repeat (27) @(negedge clk);
        selA = 1'b1;
        gateA = 16'd5;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        waitDone(1'b0, 29, lat);
        chk("t5_latency", lat, 90);
        chk("t5_count_10pm1", (countA >= 9 && countA <= 11), 1);
        chk("t5_enable_monitor", enErrA, 0);
        @(negedge clk);

        // Reset in the middle of MEASURE drops everything next cycle.
        kickA(1'b0, 16'd80);
        repeat (19) @(negedge clk);
        chk("t5_busy_before_reset", busyA, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5r_ro_en", roEnA, 0);
        chk("t5r_busy", busyA, 0);
        chk("t5r_count", countA, 0);
        chk("t5r_done", doneA, 0);
        reset = 1'b0;
        @(negedge clk);

        // Zero gate window; start on the done cycle ignored, one later accepted.
        kickA(1'b1, 16'd0);
        waitDone(1'b0, 1, lat);
        chk("t6_latency", lat, 10);
        chk("t6_count", countA, 0);
        selA = 1'b0;
        gateA = 16'd0;
        startA = 1'b1;
        @(negedge clk);
        chk("t6_start_on_done_ignored", busyA, 0);
        chk("t6_done_one_cycle", doneA, 0);
        expEnA = 2'b01;
        @(negedge clk);
        startA = 1'b0;
        chk("t6_next_start_busy", busyA, 1);
        chk("t6_next_start_ro_en", roEnA, 2'b01);
        waitDone(1'b0, 1, lat);
        chk("t6_next_latency", lat, 10);
        chk("t6_next_count", countA, 0);
        @(negedge clk);
        chk("final_enable_monitor_a", enErrA, 0);
        chk("final_enable_monitor_b", enErrB, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
